// File: rtl/tlc_mon_pkg.sv
// Shared types for the traffic-light lamp monitor: phase encoding, per-direction
// lamp classes and the legal phase-transition rule.
package tlc_mon_pkg;

   typedef enum logic [2:0] {
      PH_IDLE = 3'd0,
      PH_G1R2 = 3'd1,
      PH_Y1R2 = 3'd2,
      PH_RR_A = 3'd3,
      PH_R1G2 = 3'd4,
      PH_R1Y2 = 3'd5,
      PH_RR_B = 3'd6
   } phase_e;

   typedef enum logic [1:0] {
      LEGAL_G = 2'd0,
      LEGAL_Y = 2'd1,
      LEGAL_R = 2'd2,
      ILLEGAL = 2'd3
   } lamp_class_e;

   function automatic lamp_class_e lamp_class(input logic g, input logic y, input logic r);
      case ({g, y, r})
         3'b100:  return LEGAL_G;
         3'b010:  return LEGAL_Y;
         3'b001:  return LEGAL_R;
         default: return ILLEGAL;
      endcase
   endfunction

   // Holding a phase, or leaving IDLE, is never a sequence error.
   function automatic logic trans_ok(input logic [2:0] from_ph, input logic [2:0] to_ph);
      logic ok;
      ok = (from_ph == to_ph) || (from_ph == PH_IDLE);
      case (from_ph)
         PH_G1R2: ok = ok || (to_ph == PH_Y1R2);
         PH_Y1R2: ok = ok || (to_ph == PH_RR_A) || (to_ph == PH_R1G2);
         PH_RR_A: ok = ok || (to_ph == PH_R1G2);
         PH_R1G2: ok = ok || (to_ph == PH_R1Y2);
         PH_R1Y2: ok = ok || (to_ph == PH_RR_B) || (to_ph == PH_G1R2);
         PH_RR_B: ok = ok || (to_ph == PH_G1R2);
         default: ok = ok;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/tlc_lamp_decode.sv
// Combinational classifier: turns the six lamp outputs into a target phase,
// an all-red indication and the two lamp-level error conditions.
module tlc_lamp_decode
   import tlc_mon_pkg::*;
(
   input  logic [5:0] lamps,
   output logic [2:0] vec_phase,
   output logic       vec_rr,
   output logic       onehot_bad,
   output logic       conflict
);

   lamp_class_e cls1;
   lamp_class_e cls2;

   assign cls1 = lamp_class(lamps[5], lamps[4], lamps[3]);
   assign cls2 = lamp_class(lamps[2], lamps[1], lamps[0]);

   // An all-red vector has no phase of its own; the FSM resolves RR_A vs RR_B.
   always_comb begin
      vec_phase  = PH_IDLE;
      vec_rr     = 1'b0;
      onehot_bad = (cls1 == ILLEGAL) || (cls2 == ILLEGAL);
      conflict   = !onehot_bad && (cls1 != LEGAL_R) && (cls2 != LEGAL_R);
      if (!onehot_bad && !conflict) begin
         if (cls1 == LEGAL_R && cls2 == LEGAL_R)
            vec_rr = 1'b1;
         else if (cls2 == LEGAL_R)
            vec_phase = (cls1 == LEGAL_G) ? PH_G1R2 : PH_Y1R2;
         else
            vec_phase = (cls2 == LEGAL_G) ? PH_R1G2 : PH_R1Y2;
      end
   end

endmodule

// File: rtl/tlc_light_monitor.sv
// Lamp-sequence monitor: phase FSM, dwell and cycle counters, and sticky
// error flags for illegal lamp patterns, transitions and dwell times.
module tlc_light_monitor
   import tlc_mon_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int MIN_GRN = 4,
   parameter int MIN_YLW = 2,
   parameter int MAX_YLW = 6
) (
   input  logic             blif_clk_net,
   input  logic             blif_reset_net,
   input  logic             GRN1,
   input  logic             YLW1,
   input  logic             RED1,
   input  logic             GRN2,
   input  logic             YLW2,
   input  logic             RED2,
   input  logic             clr_err,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] dwell,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             err_onehot,
   output logic             err_conflict,
   output logic             err_seq,
   output logic             err_min_grn,
   output logic             err_yellow_time,
   output logic             err_any
);

   logic [2:0]       vec_phase;
   logic             vec_rr;
   logic             onehot_bad;
   logic             conflict;
   logic [2:0]       tgt_phase;
   logic [2:0]       phase_nxt;
   logic [CNT_W-1:0] dwell_nxt;
   logic [CNT_W-1:0] cycle_nxt;
   logic [4:0]       flags_nxt;
   logic [4:0]       events;
   logic             lamp_err;
   logic             changed;
   logic             timing_on;
   logic             in_green;
   logic             in_yellow;

   tlc_lamp_decode u_decode (
      .lamps      ({GRN1, YLW1, RED1, GRN2, YLW2, RED2}),
      .vec_phase  (vec_phase),
      .vec_rr     (vec_rr),
      .onehot_bad (onehot_bad),
      .conflict   (conflict)
   );

   // All-red after a direction-1 phase is RR_A, after direction-2 is RR_B;
   // out of a green this is a sequence error but still resyncs that way.
   always_comb begin
      tgt_phase = vec_phase;
      if (vec_rr) begin
         case (phase)
            PH_G1R2, PH_Y1R2: tgt_phase = PH_RR_A;
            PH_R1G2, PH_R1Y2: tgt_phase = PH_RR_B;
            PH_RR_A, PH_RR_B: tgt_phase = phase;
            default:          tgt_phase = PH_IDLE;
         endcase
      end
   end

   always_comb begin
      lamp_err  = onehot_bad || conflict;
      phase_nxt = lamp_err ? PH_IDLE : tgt_phase;
      changed   = (phase_nxt != phase);
      timing_on = !lamp_err && (phase != PH_IDLE);
      in_green  = (phase == PH_G1R2) || (phase == PH_R1G2);
      in_yellow = (phase == PH_Y1R2) || (phase == PH_R1Y2);

      events    = '0;
      events[4] = onehot_bad;
      events[3] = conflict;
      events[2] = !lamp_err && !trans_ok(phase, tgt_phase);
      events[1] = timing_on && changed && in_green && (dwell < CNT_W'(MIN_GRN));
      events[0] = timing_on && in_yellow &&
                  ((changed && (dwell < CNT_W'(MIN_YLW))) ||
                   (!changed && (dwell == CNT_W'(MAX_YLW))));

      flags_nxt = ({err_onehot, err_conflict, err_seq, err_min_grn, err_yellow_time}
                   & {5{~clr_err}}) | events;

      if (phase_nxt == PH_IDLE)
         dwell_nxt = '0;
      else if (changed)
         dwell_nxt = CNT_W'(1);
      else if (dwell == {CNT_W{1'b1}})
         dwell_nxt = dwell;
      else
         dwell_nxt = dwell + CNT_W'(1);

      cycle_nxt = cycle_cnt;
      if (!lamp_err && tgt_phase == PH_G1R2 && (phase == PH_R1Y2 || phase == PH_RR_B))
         cycle_nxt = cycle_cnt + CNT_W'(1);
   end

   always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
      if (blif_reset_net) begin
         phase           <= PH_IDLE;
         dwell           <= '0;
         cycle_cnt       <= '0;
         err_onehot      <= 1'b0;
         err_conflict    <= 1'b0;
         err_seq         <= 1'b0;
         err_min_grn     <= 1'b0;
         err_yellow_time <= 1'b0;
         err_any         <= 1'b0;
      end else begin
         phase           <= phase_nxt;
         dwell           <= dwell_nxt;
         cycle_cnt       <= cycle_nxt;
         err_onehot      <= flags_nxt[4];
         err_conflict    <= flags_nxt[3];
         err_seq         <= flags_nxt[2];
         err_min_grn     <= flags_nxt[1];
         err_yellow_time <= flags_nxt[0];
         err_any         <= |flags_nxt;
      end
   end

endmodule

// File: tb/tb_tlc_light_monitor.sv
// Self-checking bench for tlc_light_monitor: directed vector table, reset
// corner case, then biased random lamp traffic against a reference model.
module tb_tlc_light_monitor;

   localparam int MIN_GRN = 4;
   localparam int MIN_YLW = 2;
   localparam int MAX_YLW = 6;

   localparam logic [5:0] V_G1R2 = 6'b100_001;
   localparam logic [5:0] V_Y1R2 = 6'b010_001;
   localparam logic [5:0] V_RR   = 6'b001_001;
   localparam logic [5:0] V_R1G2 = 6'b001_100;
   localparam logic [5:0] V_R1Y2 = 6'b001_010;
   localparam logic [5:0] V_GY1  = 6'b110_001;
   localparam logic [5:0] V_GG   = 6'b100_100;

   logic       blif_clk_net = 1'b0;
   logic       blif_reset_net = 1'b1;
   logic       GRN1 = 1'b0, YLW1 = 1'b0, RED1 = 1'b0;
   logic       GRN2 = 1'b0, YLW2 = 1'b0, RED2 = 1'b0;
   logic       clr_err = 1'b0;
   logic [2:0] phase;
   logic [7:0] dwell;
   logic [7:0] cycle_cnt;
   logic       err_onehot, err_conflict, err_seq, err_min_grn, err_yellow_time, err_any;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [5:0] lamps;
      logic       clr;
      logic [2:0] ph;
      logic [7:0] dw;
      logic [7:0] cy;
      logic [4:0] fl;
   } vec_t;

   vec_t vt[$];

   tlc_light_monitor #(.CNT_W(8), .MIN_GRN(MIN_GRN), .MIN_YLW(MIN_YLW), .MAX_YLW(MAX_YLW)) dut (
      .blif_clk_net    (blif_clk_net),
      .blif_reset_net  (blif_reset_net),
      .GRN1            (GRN1),
      .YLW1            (YLW1),
      .RED1            (RED1),
      .GRN2            (GRN2),
      .YLW2            (YLW2),
      .RED2            (RED2),
      .clr_err         (clr_err),
      .phase           (phase),
      .dwell           (dwell),
      .cycle_cnt       (cycle_cnt),
      .err_onehot      (err_onehot),
      .err_conflict    (err_conflict),
      .err_seq         (err_seq),
      .err_min_grn     (err_min_grn),
      .err_yellow_time (err_yellow_time),
      .err_any         (err_any)
   );

   always #5 blif_clk_net = ~blif_clk_net;

   // Reference model: phases as small integers, legality from a successor table.
   int       m_phase, m_dwell, m_cyc;
   bit [4:0] m_flags;
   bit [6:0] succ [7] = '{7'b0000000, 7'b0000100, 7'b0011000, 7'b0010000,
                          7'b0100000, 7'b1000010, 7'b0000010};

   task automatic model_reset();
      m_phase = 0;
      m_dwell = 0;
      m_cyc   = 0;
      m_flags = '0;
   endtask

   task automatic model_step(input logic [5:0] l, input logic c);
      bit [4:0] ev;
      bit       lamp_err;
      int       tgt;
      ev = '0;
      lamp_err = 1'b0;
      if ($countones(l[5:3]) != 1 || $countones(l[2:0]) != 1) begin
         ev[4] = 1'b1;
         lamp_err = 1'b1;
      end else if (!l[3] && !l[0]) begin
         ev[3] = 1'b1;
         lamp_err = 1'b1;
      end
      if (lamp_err)
         tgt = 0;
      else if (l[3] && l[0])
         tgt = (m_phase inside {1, 2}) ? 3 : (m_phase inside {4, 5}) ? 6 : m_phase;
      else if (l[0])
         tgt = l[5] ? 1 : 2;
      else
         tgt = l[2] ? 4 : 5;
      if (!lamp_err && m_phase != 0) begin
         if (tgt != m_phase && !succ[m_phase][tgt]) ev[2] = 1'b1;
         if (tgt != m_phase && (m_phase inside {1, 4}) && m_dwell < MIN_GRN) ev[1] = 1'b1;
         if ((m_phase inside {2, 5}) &&
             ((tgt != m_phase && m_dwell < MIN_YLW) || (tgt == m_phase && m_dwell == MAX_YLW)))
            ev[0] = 1'b1;
      end
      if (!lamp_err && tgt == 1 && (m_phase inside {5, 6})) m_cyc = (m_cyc + 1) % 256;
      if (tgt == 0)            m_dwell = 0;
      else if (tgt != m_phase) m_dwell = 1;
      else if (m_dwell < 255)  m_dwell = m_dwell + 1;
      m_flags = (c ? 5'b0 : m_flags) | ev;
      m_phase = tgt;
   endtask

   task automatic cmp(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic checkOutput(input string name, input int ph, input int dw, input int cy, input logic [4:0] fl);
      cmp({name, ".phase"}, int'(phase), ph);
      cmp({name, ".dwell"}, int'(dwell), dw);
      cmp({name, ".cycle_cnt"}, int'(cycle_cnt), cy);
      cmp({name, ".flags"}, int'({err_onehot, err_conflict, err_seq, err_min_grn, err_yellow_time}), int'(fl));
      cmp({name, ".err_any"}, int'(err_any), int'(|fl));
   endtask

   // Called at a falling edge; returns at the next falling edge with outputs settled.
   task automatic applyStimulus(input logic [5:0] l, input logic c);
      {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = l;
      clr_err = c;
      @(posedge blif_clk_net);
      @(negedge blif_clk_net);
   endtask

   task automatic add(input logic [5:0] l, input logic c, input logic [2:0] ph,
                      input logic [7:0] dw, input logic [7:0] cy, input logic [4:0] fl);
      vec_t v;
      v.lamps = l; v.clr = c; v.ph = ph; v.dw = dw; v.cy = cy; v.fl = fl;
      vt.push_back(v);
   endtask

   task automatic do_reset();
      blif_reset_net = 1'b1;
      {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = V_RR;
      clr_err = 1'b0;
      @(negedge blif_clk_net);
      @(negedge blif_clk_net);
      blif_reset_net = 1'b0;
   endtask

   logic [5:0] seq_vec [6] = '{V_G1R2, V_Y1R2, V_RR, V_R1G2, V_R1Y2, V_RR};

   initial begin
      // Flags order: {onehot, conflict, seq, min_grn, yellow_time}
      add(V_RR,   0, 0, 0, 0, 5'b00000);
      add(V_RR,   0, 0, 0, 0, 5'b00000);
      add(V_RR,   0, 0, 0, 0, 5'b00000);
      add(V_G1R2, 0, 1, 1, 0, 5'b00000);
      for (int i = 2; i <= 5; i++) add(V_G1R2, 0, 1, 8'(i), 0, 5'b00000);
      for (int i = 1; i <= 3; i++) add(V_Y1R2, 0, 2, 8'(i), 0, 5'b00000);
      add(V_RR,   0, 3, 1, 0, 5'b00000);
      for (int i = 1; i <= 5; i++) add(V_R1G2, 0, 4, 8'(i), 0, 5'b00000);
      for (int i = 1; i <= 3; i++) add(V_R1Y2, 0, 5, 8'(i), 0, 5'b00000);
      add(V_RR,   0, 6, 1, 0, 5'b00000);
      add(V_G1R2, 0, 1, 1, 1, 5'b00000);
      add(V_G1R2, 0, 1, 2, 1, 5'b00000);
      add(V_Y1R2, 0, 2, 1, 1, 5'b00010);
      add(V_Y1R2, 1, 2, 2, 1, 5'b00000);
      for (int i = 3; i <= 6; i++) add(V_Y1R2, 0, 2, 8'(i), 1, 5'b00000);
      add(V_Y1R2, 0, 2, 7, 1, 5'b00001);
      add(V_Y1R2, 1, 2, 8, 1, 5'b00000);
      add(V_Y1R2, 0, 2, 9, 1, 5'b00000);
      add(V_GY1,  0, 0, 0, 1, 5'b10000);
      add(V_RR,   1, 0, 0, 1, 5'b00000);
      add(V_G1R2, 0, 1, 1, 1, 5'b00000);
      add(V_GG,   0, 0, 0, 1, 5'b01000);
      add(V_G1R2, 1, 1, 1, 1, 5'b00000);
      add(V_R1G2, 0, 4, 1, 1, 5'b00110);
      add(V_R1G2, 0, 4, 2, 1, 5'b00110);
      add(V_G1R2, 1, 1, 1, 1, 5'b00110);

      {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = V_RR;
      @(negedge blif_clk_net);
      checkOutput("reset", 0, 0, 0, 5'b00000);
      blif_reset_net = 1'b0;

      foreach (vt[i]) begin
         applyStimulus(vt[i].lamps, vt[i].clr);
         checkOutput($sformatf("vec%0d", i), vt[i].ph, vt[i].dw, vt[i].cy, vt[i].fl);
      end

      // Asynchronous reset in the middle of a green phase, then resume from IDLE.
      applyStimulus(V_G1R2, 0);
      applyStimulus(V_G1R2, 0);
      #2 blif_reset_net = 1'b1;
      #1 checkOutput("async_reset", 0, 0, 0, 5'b00000);
      @(negedge blif_clk_net);
      blif_reset_net = 1'b0;
      applyStimulus(V_Y1R2, 0);
      checkOutput("post_reset", 2, 1, 0, 5'b00000);

      do_reset();
      model_reset();
      begin
         int         pos = 0;
         logic [5:0] cur = V_RR;
         logic       c;
         int         r;
         for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 62) begin
            end else if (r < 86) begin
               pos = (pos + 1) % 6;
               cur = seq_vec[pos];
            end else if (r < 94) begin
               pos = $urandom_range(0, 5);
               cur = seq_vec[pos];
            end else begin
               cur = 6'($urandom_range(0, 63));
            end
            c = ($urandom_range(0, 19) == 0);
            applyStimulus(cur, c);
            model_step(cur, c);
            checkOutput($sformatf("rand%0d", n), m_phase, m_dwell, m_cyc, m_flags);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
